fetch_decode_stage: RTL
=======================

Name: fetch_decode_stage

Overview:
- Upstream neighbour of register_file: fetches instructions and presents the decoded read/write fields to the register file.
- Holds the PC and drives a synchronous-read instruction memory.
- Registers each returned word into an IF/ID pipeline register.
- Decodes rd/rs1/rs2 and the register write enable, with stall and branch-redirect (flush) handling.

Parameters:
RESET_PC  32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
XLEN  32  datapath/PC width; only 32 supported

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hold request from downstream; freezes fetch and IF/ID
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 0)
imem_req  output  1  instruction memory read enable
imem_addr  output  32  instruction memory byte address
imem_rdata  input  32  read data, valid the cycle after imem_req=1; holds its value while imem_req=0
instruction_memory  output  32  IF/ID instruction word to register_file
rd  output  5  instruction_memory[11:7]
rs1_address  output  5  instruction_memory[19:15]
rs2_address  output  5  instruction_memory[24:20]
en  output  1  register write enable for rd
id_valid  output  1  IF/ID holds a valid instruction
id_pc  output  32  PC of the IF/ID instruction
illegal  output  1  id_valid and opcode not RV32I

Behaviour:
- Interface contract: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, immediate):
  - pc=RESET_PC; fetch_pc_q=0; fetch_valid_q=0; state=BOOT.
  - instruction_memory=0; id_pc=0; id_valid=0.
  - en=0, illegal=0, rd/rs1_address/rs2_address=0.
- Memory interface:
  - imem_addr=pc, combinational.
  - imem_req = state!=BOOT-in-reset && !stall; redirect_valid forces imem_req=1.
- FSM states: BOOT, RUN, HOLD, FLUSH.
  - BOOT: first cycle after reset release. imem_req=1, no capture. Next state RUN; fetch_valid_q<=1, fetch_pc_q<=pc, pc<=pc+4.
  - RUN:
    - If fetch_valid_q: IF/ID <= {imem_rdata, fetch_pc_q} and id_valid<=1.
    - Then fetch_pc_q<=pc and pc<=pc+4.
  - HOLD (entered whenever stall=1 without redirect): pc, fetch_pc_q, fetch_valid_q and IF/ID all hold; imem_req=0. Leave to RUN in the first cycle with stall=0.
  - FLUSH (entered on redirect_valid): the cycle after a redirect. imem_rdata is wrong-path and is discarded; id_valid=0. Next state RUN with fetch_valid_q=1.
- Redirect (any state except reset), at the edge:
  - pc<=redirect_pc; fetch_valid_q<=0; id_valid<=0; state<=FLUSH.
  - redirect_valid has priority over stall.
- Latency:
  - Reset release to first id_valid: 2 cycles.
  - Redirect edge to id_valid of target: 2 bubble cycles (id_valid low in 2 cycles), then the target instruction.
- PC arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Decode (combinational from IF/ID; opcode=instruction_memory[6:0]):
  - Write opcodes: 0110111, 0010111, 1101111, 1100111, 0000011, 0010011, 0110011.
  - en = id_valid && opcode is a write opcode && rd!=0.
  - illegal = id_valid && (instruction_memory[1:0]!=2'b11 || opcode not in {write opcodes, 1100011, 0100011, 0001111, 1110011}).
  - Illegal instructions force en=0.
- Stall with fetch_valid_q=0 (e.g. right after redirect): stays bubble, no capture.

Test Plan:
- Reset sequencing: RESET_PC=0, memory word i=32'h0000_0013+(i<<7), release rst_n -> imem_addr 0,4,8,...; id_valid rises 2 cycles after release; id_pc 0,4,8; rd 0,1,2; en=0 for rd=0 and 1 afterwards.
- Stall: stall=1 for 3 cycles while id_pc=8 -> id_pc, instruction_memory and imem_addr frozen, imem_req=0. Release -> id_pc 12 next cycle, no instruction skipped or duplicated.
- Redirect: redirect_valid=1, redirect_pc=32'h0000_0103 at id_pc=12 -> imem_addr=32'h100 next cycle; id_valid=0 for 2 cycles; then id_pc=32'h100.
- Redirect during stall: stall=1 and redirect_valid=1 same cycle -> redirect taken, state FLUSH, pc=target.
- Decode: 32'h00B50633 (add x12,x10,x11) -> rd=12, rs1=10, rs2=11, en=1. 32'h00B52023 (sw) -> en=0, illegal=0. 32'hFFFFFFFF -> illegal=1, en=0.
- Wrap and async reset: RESET_PC=32'hFFFF_FFF8 -> imem_addr FFFF_FFF8, FFFF_FFFC, 0. Assert rst_n mid-run between edges -> id_valid and en drop immediately; pc=RESET_PC.

Source files
------------

// File: rtl/fetch_decode_stage.sv
// Fetch and decode front end: owns the PC, drives a synchronous-read instruction
// memory, registers returned words into IF/ID and decodes register-file fields.
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instruction_memory,
    output logic [4:0]      rd,
    output logic [4:0]      rs1_address,
    output logic [4:0]      rs2_address,
    output logic            en,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic            illegal
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [XLEN-1:0] WORD_MASK    = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] RESET_PC_ALN = RESET_PC & WORD_MASK;

    // Opcodes that write a result into rd.
    function automatic logic is_write_opcode(input logic [6:0] op);
        logic hit;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_IMM, OP_REG:           hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Any RV32I base opcode with the 32-bit encoding marker in bits [1:0].
    function automatic logic is_legal_opcode(input logic [6:0] op);
        logic hit;
        case (op)
            OP_BRANCH, OP_STORE, OP_FENCE, OP_SYSTEM: hit = 1'b1;
            default:                                  hit = is_write_opcode(op);
        endcase
        return hit && (op[1:0] == 2'b11);
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   fetch_pc_r;
    logic              fetch_valid_r;
    logic [XLEN-1:0]   instr_r;
    logic [XLEN-1:0]   id_pc_r;
    logic              id_valid_r;
    logic              advance_s;
    logic              capture_s;
    logic              req_s;
    logic              illegal_s;
    logic              en_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state: a redirect wins over stall in every state.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BOOT, ST_RUN, ST_HOLD, ST_FLUSH: begin
                if (redirect_valid) begin
                    state_next_s = ST_FLUSH;
                end else if (stall) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: state_next_s = ST_BOOT;
        endcase
    end

    // FSM outputs: fetch advance, IF/ID capture and memory request.
    always_comb begin
        advance_s = 1'b0;
        capture_s = 1'b0;
        if (redirect_valid) begin
            advance_s = 1'b0;
        end else if (stall) begin
            advance_s = 1'b0;
        end else begin
            advance_s = 1'b1;
            case (state_r)
                ST_RUN, ST_HOLD:   capture_s = fetch_valid_r;
                ST_BOOT, ST_FLUSH: capture_s = 1'b0;
                default:           capture_s = 1'b0;
            endcase
        end
        if (!rst_n) begin
            req_s = 1'b0;
        end else begin
            req_s = redirect_valid || !stall;
        end
    end

    // PC and in-flight fetch tracking; fetch_pc_r names the word arriving next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC_ALN;
            fetch_pc_r    <= 32'h0000_0000;
            fetch_valid_r <= 1'b0;
        end else if (redirect_valid) begin
            pc_r          <= redirect_pc & WORD_MASK;
            fetch_valid_r <= 1'b0;
        end else if (advance_s) begin
            pc_r          <= pc_r + 32'd4;
            fetch_pc_r    <= pc_r;
            fetch_valid_r <= 1'b1;
        end else begin
            pc_r          <= pc_r;
            fetch_pc_r    <= fetch_pc_r;
            fetch_valid_r <= fetch_valid_r;
        end
    end

    // IF/ID pipeline register; word and PC are kept on a bubble, only valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r    <= 32'h0000_0000;
            id_pc_r    <= 32'h0000_0000;
            id_valid_r <= 1'b0;
        end else if (redirect_valid) begin
            id_valid_r <= 1'b0;
        end else if (capture_s) begin
            instr_r    <= imem_rdata;
            id_pc_r    <= fetch_pc_r;
            id_valid_r <= 1'b1;
        end else if (advance_s) begin
            id_valid_r <= 1'b0;
        end else begin
            id_valid_r <= id_valid_r;
        end
    end

    // Decode of the IF/ID word.
    always_comb begin
        illegal_s = 1'b0;
        en_s      = 1'b0;
        if (id_valid_r) begin
            illegal_s = !is_legal_opcode(instr_r[6:0]);
            en_s      = !illegal_s && is_write_opcode(instr_r[6:0])
                        && (instr_r[11:7] != 5'd0);
        end else begin
            illegal_s = 1'b0;
            en_s      = 1'b0;
        end
    end

    assign imem_req           = req_s;
    assign imem_addr          = pc_r;
    assign instruction_memory = instr_r;
    assign rd                 = instr_r[11:7];
    assign rs1_address        = instr_r[19:15];
    assign rs2_address        = instr_r[24:20];
    assign id_valid           = id_valid_r;
    assign id_pc              = id_pc_r;
    assign en                 = en_s;
    assign illegal            = illegal_s;

endmodule
